// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: decode/execute hazard fields in, forwarding selects and stall/flush controls out.
interface hazard_ctrl_if;
   logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
   logic        reg_write_e, pc_src_e, mc_start_e;
   logic [1:0]  res_src_e;
   logic [1:0]  forward_a_e, forward_b_e;
   logic        stall_f, stall_d, stall_e, flush_d, flush_e, mc_busy;
   logic [31:0] stall_cycles, flush_events;
   modport master (
      output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, reg_write_e, res_src_e, pc_src_e, mc_start_e,
      input  forward_a_e, forward_b_e, stall_f, stall_d, stall_e, flush_d, flush_e, mc_busy,
             stall_cycles, flush_events
   );
   modport slave (
      input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, reg_write_e, res_src_e, pc_src_e, mc_start_e,
      output forward_a_e, forward_b_e, stall_f, stall_d, stall_e, flush_d, flush_e, mc_busy,
             stall_cycles, flush_events
   );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding selects, load-use/branch/multi-cycle stall and flush control.
// Optional stall/flush performance counters are built when HAZ_PERF_CNT_EN is defined.
module hazard_ctrl #(
   parameter int MC_LATENCY = 3,
   parameter int CNT_W      = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   hazard_ctrl_if.slave hz
);
   typedef enum logic {IDLE, BUSY} state_t;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MC_LATENCY >= 2 ? MC_LATENCY - 2 : 0);
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [4:0]       rd_m, rd_w;
   logic             reg_write_m, reg_write_w;
   logic             mc_stall, lw_stall;

   function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
      return (reg_write_m && rd_m != 5'd0 && rd_m == rs) ? 2'b10 :
             (reg_write_w && rd_w != 5'd0 && rd_w == rs) ? 2'b01 : 2'b00;
   endfunction

   always_comb begin
      mc_stall       = (state == IDLE) ? (hz.mc_start_e && MC_LATENCY >= 2) : (cnt != '0);
      lw_stall       = hz.res_src_e == 2'b01 && hz.reg_write_e && hz.rd_e != 5'd0 &&
                       (hz.rd_e == hz.rs1_d || hz.rd_e == hz.rs2_d);
      hz.forward_a_e = fwd_sel(hz.rs1_e);
      hz.forward_b_e = fwd_sel(hz.rs2_e);
      hz.stall_f     = mc_stall || lw_stall;
      hz.stall_d     = mc_stall || lw_stall;
      hz.stall_e     = mc_stall;
      hz.flush_d     = !mc_stall && hz.pc_src_e;
      hz.flush_e     = !mc_stall && (lw_stall || hz.pc_src_e);
      hz.mc_busy     = state == BUSY;
   end

   // A stalled E sends a bubble into M; W always follows M.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         rd_m        <= '0;
         reg_write_m <= 1'b0;
         rd_w        <= '0;
         reg_write_w <= 1'b0;
      end else begin
         rd_m        <= mc_stall ? 5'd0 : hz.rd_e;
         reg_write_m <= !mc_stall && hz.reg_write_e;
         rd_w        <= rd_m;
         reg_write_w <= reg_write_m;
         if (state == IDLE) begin
            if (mc_stall) begin
               state <= BUSY;
               cnt   <= CNT_INIT;
            end
         end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
         end else begin
            state <= IDLE;
         end
      end
   end

`ifdef HAZ_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hz.stall_cycles <= '0;
         hz.flush_events <= '0;
      end else begin
         hz.stall_cycles <= hz.stall_cycles + 32'(hz.stall_f);
         hz.flush_events <= hz.flush_events + 32'(hz.flush_d);
      end
   end
`else
   assign hz.stall_cycles = '0;
   assign hz.flush_events = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: cycle-by-cycle directed vectors for hazard_ctrl plus reset-in-BUSY sequence.
module tb_hazard_ctrl;
   typedef struct packed {
      logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
      logic       rw;
      logic [1:0] res;
      logic       pc, mc;
      logic [1:0] fa, fb;
      logic [4:0] st;
      logic       busy;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   vec_t tbl [23];
   hazard_ctrl_if hz();

   hazard_ctrl #(.MC_LATENCY(3), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .hz(hz));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      hz.rs1_d = v.rs1_d; hz.rs2_d = v.rs2_d;
      hz.rs1_e = v.rs1_e; hz.rs2_e = v.rs2_e; hz.rd_e = v.rd_e;
      hz.reg_write_e = v.rw; hz.res_src_e = v.res;
      hz.pc_src_e = v.pc; hz.mc_start_e = v.mc;
   endtask

   function automatic logic [4:0] stalls();
      return {hz.stall_f, hz.stall_d, hz.stall_e, hz.flush_d, hz.flush_e};
   endfunction

   initial begin
      int exp_sc, exp_fe;
      vec_t z;
      z = '0;
      //        rs1_d  rs2_d  rs1_e  rs2_e  rd_e  rw    res    pc    mc    fa     fb     sf sd se fd fe  busy
      tbl[0]  = '{5'd0, 5'd0, 5'd0,  5'd0,  5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 5'b00000, 1'b0};
      tbl[1]  = '{5'd0, 5'd0, 5'd1,  5'd2,  5'd5, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 5'b00000, 1'b0};
      tbl[2]  = '{5'd0, 5'd0, 5'd5,  5'd5,  5'd7, 1'b1, 2'b00, 1'b0, 1'b0, 2'b10, 2'b10, 5'b00000, 1'b0};
      tbl[3]  = '{5'd0, 5'd0, 5'd3,  5'd5,  5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b01, 5'b00000, 1'b0};
      tbl[4]  = '{5'd0, 5'd0, 5'd7,  5'd0,  5'd9, 1'b1, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 5'b00000, 1'b0};
      tbl[5]  = '{5'd0, 5'd0, 5'd9,  5'd9,  5'd9, 1'b1, 2'b00, 1'b0, 1'b0, 2'b10, 2'b10, 5'b00000, 1'b0};
      tbl[6]  = '{5'd0, 5'd0, 5'd9,  5'd9,  5'd0, 1'b1, 2'b00, 1'b0, 1'b0, 2'b10, 2'b10, 5'b00000, 1'b0};
      tbl[7]  = '{5'd0, 5'd0, 5'd0,  5'd9,  5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b01, 5'b00000, 1'b0};
      tbl[8]  = '{5'd1, 5'd6, 5'd0,  5'd0,  5'd6, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 5'b11001, 1'b0};
      tbl[9]  = '{5'd1, 5'd6, 5'd0,  5'd0,  5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 5'b00000, 1'b0};
      tbl[10] = '{5'd0, 5'd0, 5'd1,  5'd6,  5'd8, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b01, 5'b00000, 1'b0};
      tbl[11] = '{5'd0, 5'd0, 5'd0,  5'd0,  5'd0, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 5'b00000, 1'b0};
      tbl[12] = '{5'd4, 5'd0, 5'd8,  5'd0,  5'd4, 1'b1, 2'b10, 1'b0, 1'b0, 2'b01, 2'b00, 5'b00000, 1'b0};
      tbl[13] = '{5'd0, 5'd0, 5'd0,  5'd0,  5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 5'b00011, 1'b0};
      tbl[14] = '{5'd0, 5'd0, 5'd0,  5'd0,  5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 5'b00000, 1'b0};
      tbl[15] = '{5'd0, 5'd0, 5'd10, 5'd10, 5'd10, 1'b1, 2'b00, 1'b1, 1'b1, 2'b00, 2'b00, 5'b11100, 1'b0};
      tbl[16] = '{5'd0, 5'd0, 5'd10, 5'd10, 5'd10, 1'b1, 2'b00, 1'b0, 1'b1, 2'b00, 2'b00, 5'b11100, 1'b1};
      tbl[17] = '{5'd0, 5'd0, 5'd10, 5'd10, 5'd10, 1'b1, 2'b00, 1'b0, 1'b1, 2'b00, 2'b00, 5'b00000, 1'b1};
      tbl[18] = '{5'd0, 5'd0, 5'd10, 5'd0,  5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b10, 2'b00, 5'b00000, 1'b0};
      tbl[19] = '{5'd3, 5'd0, 5'd0,  5'd10, 5'd3, 1'b1, 2'b01, 1'b0, 1'b1, 2'b00, 2'b01, 5'b11100, 1'b0};
      tbl[20] = '{5'd3, 5'd0, 5'd0,  5'd10, 5'd3, 1'b1, 2'b01, 1'b0, 1'b1, 2'b00, 2'b00, 5'b11100, 1'b1};
      tbl[21] = '{5'd3, 5'd0, 5'd0,  5'd10, 5'd3, 1'b1, 2'b01, 1'b0, 1'b1, 2'b00, 2'b00, 5'b11001, 1'b1};
      tbl[22] = '{5'd0, 5'd0, 5'd0,  5'd0,  5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 5'b00000, 1'b0};
      drive(z);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset fa", 32'(hz.forward_a_e), 32'd0);
      check("reset fb", 32'(hz.forward_b_e), 32'd0);
      check("reset stalls", 32'(stalls()), 32'd0);
      check("reset busy", 32'(hz.mc_busy), 32'd0);
      check("reset stall_cycles", hz.stall_cycles, 32'd0);
      rst_n = 1'b1;
      exp_sc = 0;
      exp_fe = 0;
      for (int i = 0; i < 23; i++) begin
         @(posedge clk);
         #1 drive(tbl[i]);
         @(negedge clk);
         check($sformatf("v%0d fwd_a", i), 32'(hz.forward_a_e), 32'(tbl[i].fa));
         check($sformatf("v%0d fwd_b", i), 32'(hz.forward_b_e), 32'(tbl[i].fb));
         check($sformatf("v%0d stall/flush", i), 32'(stalls()), 32'(tbl[i].st));
         check($sformatf("v%0d mc_busy", i), 32'(hz.mc_busy), 32'(tbl[i].busy));
         exp_sc += int'(tbl[i].st[4]);
         exp_fe += int'(tbl[i].st[1]);
      end
      @(posedge clk);
      #1 drive(z);
`ifdef HAZ_PERF_CNT_EN
      check("stall_cycles", hz.stall_cycles, 32'(exp_sc));
      check("flush_events", hz.flush_events, 32'(exp_fe));
`else
      check("stall_cycles off", hz.stall_cycles, 32'd0);
      check("flush_events off", hz.flush_events, 32'd0);
`endif
      // Reset while BUSY with cnt=1 must abort the op without a clock edge.
      hz.mc_start_e = 1'b1;
      @(posedge clk);
      #1;
      check("pre-reset busy", 32'(hz.mc_busy), 32'd1);
      check("pre-reset stall_e", 32'(hz.stall_e), 32'd1);
      hz.mc_start_e = 1'b0;
      rst_n = 1'b0;
      #1;
      check("mid-busy reset stalls", 32'(stalls()), 32'd0);
      check("mid-busy reset busy", 32'(hz.mc_busy), 32'd0);
      check("mid-busy reset stall_cycles", hz.stall_cycles, 32'd0);
      check("mid-busy reset fwd", 32'({hz.forward_a_e, hz.forward_b_e}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post-reset busy", 32'(hz.mc_busy), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
